osd_overlay: RTL

//  Text on-screen-display mixer sitting directly downstream of the scan doubler.

---
 rtl/osd_pkg.sv | 23 ++
 rtl/osd_font_rom.sv | 62 ++++++
 rtl/osd_overlay.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/osd_pkg.sv
// Shared types and constants for the text OSD mixer.
// Imported by the font ROM and the overlay top.
package osd_pkg;

  typedef enum logic {
    HIDDEN,
    SHOWN
  } osd_fsm_t;

  typedef enum logic [1:0] {
    NONE,
    SHOW,
    HIDE
  } req_t;

  localparam int CELL_W = 8;

  localparam logic [8:0] OSD_FG = 9'h1FF;
  localparam logic [8:0] OSD_BG = 9'h007;
  localparam logic [8:0] VID_WHITE = 9'h1FF;
  localparam logic [8:0] VID_BLACK = 9'h000;

endpackage

// File: rtl/osd_font_rom.sv
// 128-glyph 8x8 font, 1024x8 synchronous ROM.
// Addressed by {code[6:0], line[2:0]}; MSB is leftmost pixel.
module osd_font_rom
  import osd_pkg::*;
(
  input  logic       clk,
  input  logic       ce,
  input  logic [9:0] addr,
  output logic [7:0] data
);

  function automatic logic [7:0] glyph(
    input logic [9:0] a
  );
    logic [7:0] g;
    g = 8'h00;
    if (a[9:3] == 7'h7F) begin
      g = 8'hFF;
    end else begin
      case (a)
        {7'h2D, 3'd3}: g = 8'h7E;
        {7'h30, 3'd0}: g = 8'h3C;
        {7'h30, 3'd1}: g = 8'h66;
        {7'h30, 3'd2}: g = 8'h6E;
        {7'h30, 3'd3}: g = 8'h76;
        {7'h30, 3'd4}: g = 8'h66;
        {7'h30, 3'd5}: g = 8'h66;
        {7'h30, 3'd6}: g = 8'h3C;
        {7'h31, 3'd0}: g = 8'h18;
        {7'h31, 3'd1}: g = 8'h38;
        {7'h31, 3'd2}: g = 8'h18;
        {7'h31, 3'd3}: g = 8'h18;
        {7'h31, 3'd4}: g = 8'h18;
        {7'h31, 3'd5}: g = 8'h18;
        {7'h31, 3'd6}: g = 8'h7E;
        {7'h41, 3'd0}: g = 8'h18;
        {7'h41, 3'd1}: g = 8'h3C;
        {7'h41, 3'd2}: g = 8'h66;
        {7'h41, 3'd3}: g = 8'h66;
        {7'h41, 3'd4}: g = 8'h7E;
        {7'h41, 3'd5}: g = 8'h66;
        {7'h41, 3'd6}: g = 8'h66;
        {7'h42, 3'd0}: g = 8'h7C;
        {7'h42, 3'd1}: g = 8'h66;
        {7'h42, 3'd2}: g = 8'h66;
        {7'h42, 3'd3}: g = 8'h7C;
        {7'h42, 3'd4}: g = 8'h66;
        {7'h42, 3'd5}: g = 8'h66;
        {7'h42, 3'd6}: g = 8'h7C;
        default:       g = 8'h00;
      endcase
    end
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (ce) begin
      data <= glyph(addr);
    end
  end

endmodule

// File: rtl/osd_overlay.sv
// Text OSD mixer behind the scan doubler: 3-tick pipeline
// (window decode, char RAM, font ROM) plus frame-synced show/hide FSM.
module osd_overlay
  import osd_pkg::*;
#(
  parameter int         OSD_X0    = 64,
  parameter int         OSD_Y0    = 40,
  parameter int         COLS      = 32,
  parameter int         ROWS      = 8,
  parameter int         TIMEOUT_W = 8,
  parameter logic [8:0] FG_RGB    = OSD_FG,
  parameter logic [8:0] BG_RGB    = OSD_BG
) (
  input  logic                 clkvga,
  input  logic                 reset,
  input  logic                 ce_2pix,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic                 v_in,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic [7:0]           wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 wr_en,
  input  logic                 osd_show,
  input  logic                 osd_hide,
  input  logic [TIMEOUT_W-1:0] osd_timeout,
  output logic [8:0]           rgb,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 osd_active
);

  localparam logic [9:0] X_LO = 10'(OSD_X0);
  localparam logic [9:0] X_HI = 10'(OSD_X0 + COLS * CELL_W);
  localparam logic [9:0] Y_LO = 10'(OSD_Y0);
  localparam logic [9:0] Y_HI = 10'(OSD_Y0 + ROWS * CELL_W);

  logic [7:0] dx;
  logic [5:0] dy;
  logic       in_win;

  assign dx = 8'(pixel_x - X_LO);
  assign dy = 6'(pixel_y - Y_LO);
  assign in_win = (pixel_x >= X_LO) && (pixel_x < X_HI) &&
                  (pixel_y >= Y_LO) && (pixel_y < Y_HI);

  logic       win1, v1, hs1, vs1;
  logic [7:0] addr1;
  logic [2:0] line1, bit1;
  logic       win2, v2, hs2, vs2;
  logic [2:0] line2, bit2;
  logic [7:0] code2;
  logic       win3, v3, hs3, vs3, inv3;
  logic [2:0] bit3;
  logic [7:0] font3;

  always_ff @(posedge clkvga) begin
    if (reset) begin
      win1  <= 1'b0;
      v1    <= 1'b0;
      hs1   <= 1'b1;
      vs1   <= 1'b0;
      addr1 <= '0;
      line1 <= '0;
      bit1  <= '0;
      win2  <= 1'b0;
      v2    <= 1'b0;
      hs2   <= 1'b1;
      vs2   <= 1'b0;
      line2 <= '0;
      bit2  <= '0;
      win3  <= 1'b0;
      v3    <= 1'b0;
      hs3   <= 1'b1;
      vs3   <= 1'b0;
      inv3  <= 1'b0;
      bit3  <= '0;
    end else if (ce_2pix) begin
      win1  <= in_win;
      v1    <= v_in;
      hs1   <= hs_in;
      vs1   <= vs_in;
      addr1 <= {dy[5:3], dx[7:3]};
      line1 <= dy[2:0];
      bit1  <= dx[2:0];
      win2  <= win1;
      v2    <= v1;
      hs2   <= hs1;
      vs2   <= vs1;
      line2 <= line1;
      bit2  <= bit1;
      win3  <= win2;
      v3    <= v2;
      hs3   <= hs2;
      vs3   <= vs2;
      inv3  <= code2[7];
      bit3  <= bit2;
    end
  end

  // Char RAM: no reset; NBA ordering gives read-first on collisions.
  logic [7:0] char_ram [256];

  always_ff @(posedge clkvga) begin
    if (wr_en) begin
      char_ram[wr_addr] <= wr_data;
    end
    if (ce_2pix) begin
      code2 <= char_ram[addr1];
    end
  end

  osd_font_rom u_font (
    .clk  (clkvga),
    .ce   (ce_2pix),
    .addr ({code2[6:0], line2}),
    .data (font3)
  );

  logic pixel;

  assign pixel  = font3[3'd7 - bit3] ^ inv3;
  assign rgb    = (osd_active && win3) ? (pixel ? FG_RGB : BG_RGB)
                                       : (v3 ? VID_WHITE : VID_BLACK);
  assign hs_out = hs3;
  assign vs_out = vs3;

  osd_fsm_t             state, state_n;
  req_t                 req, req_n, req_in;
  logic [TIMEOUT_W-1:0] cnt, cnt_n;
  logic                 vs_prev, vs_rise;

  assign vs_rise    = ce_2pix && vs_in && !vs_prev;
  assign osd_active = (state == SHOWN);

  always_ff @(posedge clkvga) begin
    if (reset) begin
      state   <= HIDDEN;
      req     <= NONE;
      cnt     <= '0;
      vs_prev <= 1'b0;
    end else begin
      state <= state_n;
      req   <= req_n;
      cnt   <= cnt_n;
      if (ce_2pix) begin
        vs_prev <= vs_in;
      end
    end
  end

  always_comb begin
    req_in = NONE;
    if (osd_hide) begin
      req_in = HIDE;
    end else if (osd_show) begin
      req_in = SHOW;
    end
  end

  // Requests are only committed at a frame boundary.
  always_comb begin
    state_n = state;
    req_n   = req;
    cnt_n   = cnt;
    if (vs_rise) begin
      req_n = NONE;
      unique case (req)
        HIDE: state_n = HIDDEN;
        SHOW: begin
          state_n = SHOWN;
          cnt_n   = osd_timeout;
        end
        default: begin
          if (state == SHOWN) begin
            if (cnt == TIMEOUT_W'(1)) begin
              state_n = HIDDEN;
            end else if (cnt != '0) begin
              cnt_n = cnt - TIMEOUT_W'(1);
            end
          end
        end
      endcase
    end
    if (req_in != NONE) begin
      req_n = req_in;
    end
  end

endmodule
